present_round_engine: RTL

PRESENT_ROUND_ENGINE -- requirements
Module: present_round_engine

---
 rtl/present_pkg.sv | 32 +++
 rtl/present_sbox.sv | 11 +
 rtl/present_round_engine.sv | 114 +++++++++++
 3 files changed

// File: rtl/present_pkg.sv
// PRESENT cipher shared constants, state enum and bit permutation.
// Define PRESENT_KEY128_EN for the 128-bit key schedule (default is 80-bit).
package present_pkg;

`ifdef PRESENT_KEY128_EN
    localparam int KW = 128;
`else
    localparam int KW = 80;
`endif

    localparam int NUM_ROUNDS = 31;

    // Entry i lives in nibble i: S(0)=C ... S(F)=2.
    localparam logic [15:0][3:0] SBOX = 64'h21748FE3DA09B65C;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    function automatic logic [63:0] p_layer(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 63; i++) begin
            y[(16 * i) % 63] = x[i];
        end
        y[63] = x[63];
        return y;
    endfunction

endpackage

// File: rtl/present_sbox.sv
// PRESENT 4-bit S-box lookup, purely combinational.
module present_sbox
    import present_pkg::*;
(
    input  logic [3:0] x_i,
    output logic [3:0] y_o
);

    assign y_o = SBOX[x_i];

endmodule

// File: rtl/present_round_engine.sv
// Iterative PRESENT encryptor: one round per clock, 31 rounds plus whitening.
// Define PRESENT_KEY128_EN for the 128-bit key schedule (default is 80-bit).
module present_round_engine
    import present_pkg::*;
(
    input  logic          clk,
    input  logic          n_reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [63:0]   plaintext,
    input  logic [KW-1:0] key,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [63:0]   ciphertext,
    output logic          busy
);

    state_e        fsm_q, fsm_d;
    logic [63:0]   text_q, text_d;
    logic [KW-1:0] key_q, key_d;
    logic [4:0]    cnt_q, cnt_d;
    logic          en_q;

    logic [63:0]   sb_in, sb_out;
    logic [KW-1:0] krot, key_upd;
    logic [3:0]    ks_hi;

    assign sb_in = text_q ^ key_q[KW-1:KW-64];

    for (genvar g = 0; g < 16; g++) begin : g_sbox
        present_sbox u_sbox (
            .x_i (sb_in[4*g +: 4]),
            .y_o (sb_out[4*g +: 4])
        );
    end

    assign krot = {key_q[KW-62:0], key_q[KW-1:KW-61]};

    present_sbox u_ks_hi (
        .x_i (krot[KW-1:KW-4]),
        .y_o (ks_hi)
    );

`ifdef PRESENT_KEY128_EN
    logic [3:0] ks_lo;

    present_sbox u_ks_lo (
        .x_i (krot[123:120]),
        .y_o (ks_lo)
    );

    assign key_upd = {ks_hi, ks_lo, krot[119:67],
                      krot[66:62] ^ cnt_q, krot[61:0]};
`else
    assign key_upd = {ks_hi, krot[75:20],
                      krot[19:15] ^ cnt_q, krot[14:0]};
`endif

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            fsm_q  <= IDLE;
            text_q <= '0;
            key_q  <= '0;
            cnt_q  <= '0;
            en_q   <= 1'b0;
        end else begin
            fsm_q  <= fsm_d;
            text_q <= text_d;
            key_q  <= key_d;
            cnt_q  <= cnt_d;
            en_q   <= 1'b1;
        end
    end

    always_comb begin
        fsm_d  = fsm_q;
        text_d = text_q;
        key_d  = key_q;
        cnt_d  = cnt_q;
        unique case (fsm_q)
            IDLE: begin
                if (in_valid && en_q) begin
                    text_d = plaintext;
                    key_d  = key;
                    cnt_d  = 5'd1;
                    fsm_d  = RUN;
                end
            end
            RUN: begin
                text_d = p_layer(sb_out);
                key_d  = key_upd;
                // Counter parks at the last round instead of wrapping.
                if (cnt_q == 5'(NUM_ROUNDS)) begin
                    fsm_d = DONE;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    fsm_d = IDLE;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    // Gated by n_reset so nothing looks valid while reset is held.
    assign in_ready   = n_reset && en_q && (fsm_q == IDLE);
    assign out_valid  = n_reset && (fsm_q == DONE);
    assign busy       = n_reset && (fsm_q == RUN || fsm_q == DONE);
    assign ciphertext = out_valid ? sb_in : 64'd0;

endmodule
